// File: rtl/mux_rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_arb_pkg
// Shared types for the registered multiplexer / round-robin arbiter:
//   mode_e  - arbitration mode (fixed select or round-robin)
//   state_e - output stage occupancy (EMPTY / FULL)
// -----------------------------------------------------------------------------
package mux_rr_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage : mux_rr_arb_pkg

// File: rtl/mux_rr_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search. Starting one past ptr, walks the
// request vector upward (wrapping from NUM_IN-1 to 0) and reports the first
// requester found. ptr itself is searched last, so the most recent winner has
// the lowest priority.
// Ports:
//   req       - per-channel request
//   ptr       - index of the last granted channel
//   grant_vld - at least one request present
//   grant_idx - index of the winning channel (0 when grant_vld=0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_IN = 9,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_vld,
    output logic [SEL_W-1:0]  grant_idx
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_IN; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!grant_vld && req[SEL_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_rr_arb.sv
// -----------------------------------------------------------------------------
// mux_rr_arb
// Selects one of NUM_IN valid/ready input channels, either by a fixed channel
// index (mode 0) or by round-robin (mode 1), and holds the selected word in a
// single-entry output register with a valid/ready handshake.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   mode       - 0 = fixed select via sel, 1 = round-robin
//   sel        - channel index used in fixed mode
//   in_data    - flattened channel words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel accept, one-hot or zero (combinational)
//   out_data   - registered selected word
//   out_src    - channel index that supplied out_data
//   out_valid  - output register holds a word
//   out_ready  - downstream accepts the held word
//   err_sel    - sticky: out-of-range sel seen in fixed mode
// -----------------------------------------------------------------------------
module mux_rr_arb
    import mux_rr_arb_pkg::*;
#(
    parameter  int NUM_IN = 9,
    parameter  int WIDTH  = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sel
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_src_q, out_src_d;
    logic               err_sel_q, err_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    mode_e              mode_s;
    logic               rr_vld;
    logic [SEL_W-1:0]   rr_idx;
    logic               fix_vld;
    logic               sel_oob;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic               load;
    logic               xfer;
    logic [WIDTH-1:0]   grant_word;

    assign mode_s = mode_e'(mode);

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant_vld (rr_vld),
        .grant_idx (rr_idx)
    );

    // Fixed-select grant. Comparing sel against each legal index means an
    // out-of-range sel simply matches nothing.
    always_comb begin
        fix_vld = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
                fix_vld = 1'b1;
            end
        end
    end

    assign sel_oob = (int'(sel) >= NUM_IN);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (mode_s == MODE_RR) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else begin
            grant_vld = fix_vld;
            grant_idx = sel;
        end
    end

    // The output register can take a new word when it is empty or when its
    // current word leaves this cycle. Reset blocks any acceptance.
    assign load = (state_q == ST_EMPTY) || out_ready;
    assign xfer = load && grant_vld && !rst;

    always_comb begin
        in_ready   = '0;
        grant_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                in_ready[k] = xfer;
                grant_word  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        err_sel_d  = err_sel_q;

        if (load) begin
            if (xfer) begin
                state_d    = ST_FULL;
                out_data_d = grant_word;
                out_src_d  = grant_idx;
                // Only round-robin winners advance the rotation.
                if (mode_s == MODE_RR) begin
                    ptr_d = grant_idx;
                end
            end else begin
                // Word drained with nothing to replace it; data/src keep
                // their last value.
                state_d = ST_EMPTY;
            end
        end

        if (mode_s == MODE_FIXED && sel_oob) begin
            err_sel_d = 1'b1;
        end
    end

    // ptr resets to the last channel so the first round-robin search starts
    // at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_src_q  <= '0;
            err_sel_q  <= 1'b0;
            ptr_q      <= SEL_W'(NUM_IN - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before the edge, independent of statement order.
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            err_sel_q  <= err_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err_sel   = err_sel_q;

endmodule : mux_rr_arb

// File: tb/tb_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arb
// Self-checking bench for mux_rr_arb (NUM_IN=9, WIDTH=16): a table of
// hand-derived cycle vectors, hand-written reset/stall sequences, and a
// randomized phase compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mux_rr_arb;

    localparam int N = 9;
    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic           mode;
    logic [3:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [3:0]     out_src;
    logic           out_valid;
    logic           out_ready;
    logic           err_sel;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_arb #(
        .NUM_IN (N),
        .WIDTH  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Fixed data pattern: channel k carries 16'h0F10 + k*16'h0101 (ch3 = 16'h1213).
    task automatic load_pattern();
        for (int k = 0; k < N; k++) begin
            in_data[k*W +: W] = 16'h0F10 + W'(k) * 16'h0101;
        end
    endtask

    // Reset pulse spanning one rising edge; returns at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic [8:0]  valid;
        logic        ready;
        logic [8:0]  exp_rdy;
        logic        exp_vld;
        logic [3:0]  exp_src;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic m, logic [3:0] s, logic [8:0] v, logic r,
                                logic [8:0] er, logic ev, logic [3:0] es,
                                logic [15:0] ed, logic ee);
        vec_t x;
        x.mode = m; x.sel = s; x.valid = v; x.ready = r;
        x.exp_rdy = er; x.exp_vld = ev; x.exp_src = es; x.exp_data = ed; x.exp_err = ee;
        return x;
    endfunction

    // Apply one vector at posedge+1, check in_ready, clock, check outputs.
    task automatic apply_vec(input vec_t v, input string tag);
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.valid;
        out_ready = v.ready;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_vld));
        if (v.exp_vld) begin
            check({tag, " out_src"}, 32'(out_src), 32'(v.exp_src));
            check({tag, " out_data"}, 32'(out_data), 32'(v.exp_data));
        end
        check({tag, " err_sel"}, 32'(err_sel), 32'(v.exp_err));
    endtask

    // -------------------------------------------------------- reference model
    // Transaction-level view: a one-word holding slot plus the last round-robin
    // winner; grant is derived directly from the arbitration rules.
    int          m_full;
    int          m_src;
    int          m_ptr;
    logic [15:0] m_data;
    bit          m_err;

    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel[3:0]]) return int'(sel);
            return -1;
        end
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [8:0] model_ready();
        int g;
        g = model_grant();
        if ((m_full == 0 || out_ready) && g >= 0) return 9'(1 << g);
        return '0;
    endfunction

    task automatic model_clock();
        int g;
        g = model_grant();
        if (m_full == 0 || out_ready) begin
            if (g >= 0) begin
                m_full = 1;
                m_src  = g;
                m_data = in_data[g*W +: W];
                if (mode) m_ptr = g;
            end else begin
                m_full = 0;
            end
        end
        if (mode == 1'b0 && int'(sel) >= N) m_err = 1'b1;
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        load_pattern();

        // Reset state, with valid inputs present during reset.
        in_valid = 9'h1FF;
        @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_src", 32'(out_src), 32'd0);
        check("reset err_sel", 32'(err_sel), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // Cycle-by-cycle vectors from reset (ptr=8, EMPTY).
        tbl.push_back(mk(0, 4'd3, 9'h1FF, 1, 9'h008, 1, 4'd3, 16'h1213, 0)); // fixed ch3
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h001, 1, 4'd0, 16'h0F10, 0)); // RR from ch0
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h002, 1, 4'd1, 16'h1011, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h004, 1, 4'd2, 16'h1112, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h008, 1, 4'd3, 16'h1213, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h010, 1, 4'd4, 16'h1314, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h020, 1, 4'd5, 16'h1415, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h040, 1, 4'd6, 16'h1516, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h080, 1, 4'd7, 16'h1617, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h100, 1, 4'd8, 16'h1718, 0));
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h001, 1, 4'd0, 16'h0F10, 0)); // wrap
        tbl.push_back(mk(1, 4'd0, 9'h084, 1, 9'h004, 1, 4'd2, 16'h1112, 0)); // ch2/ch7 only
        tbl.push_back(mk(1, 4'd0, 9'h084, 1, 9'h080, 1, 4'd7, 16'h1617, 0));
        tbl.push_back(mk(1, 4'd0, 9'h084, 1, 9'h004, 1, 4'd2, 16'h1112, 0));
        tbl.push_back(mk(1, 4'd0, 9'h084, 1, 9'h080, 1, 4'd7, 16'h1617, 0));
        tbl.push_back(mk(1, 4'd0, 9'h084, 0, 9'h000, 1, 4'd7, 16'h1617, 0)); // stall
        tbl.push_back(mk(1, 4'd0, 9'h084, 0, 9'h000, 1, 4'd7, 16'h1617, 0));
        tbl.push_back(mk(1, 4'd0, 9'h000, 1, 9'h000, 0, 4'd7, 16'h1617, 0)); // drain to EMPTY
        tbl.push_back(mk(1, 4'd0, 9'h000, 0, 9'h000, 0, 4'd7, 16'h1617, 0)); // idle
        tbl.push_back(mk(0, 4'hF, 9'h1FF, 1, 9'h000, 0, 4'd7, 16'h1617, 1)); // bad sel
        tbl.push_back(mk(0, 4'd5, 9'h1FF, 1, 9'h020, 1, 4'd5, 16'h1415, 1)); // err sticky
        tbl.push_back(mk(1, 4'd0, 9'h1FF, 1, 9'h100, 1, 4'd8, 16'h1718, 1)); // ptr kept at 7
        tbl.push_back(mk(0, 4'd2, 9'h1FB, 1, 9'h000, 0, 4'd8, 16'h1718, 1)); // sel ch invalid

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Held-out data is captured at the edge, not before.
        check("empty holds out_data", 32'(out_data), 32'h1718);
        check("empty holds out_src", 32'(out_src), 32'd8);

        // Stall: word 16'hfefd held for 5 cycles under back-pressure.
        do_reset();
        check("err cleared by reset", 32'(err_sel), 32'd0);
        in_data[4*W +: W] = 16'hFEFD;
        apply_vec(mk(0, 4'd4, 9'h1FF, 0, 9'h010, 1, 4'd4, 16'hFEFD, 0), "stall load");
        for (int c = 0; c < 5; c++) begin
            apply_vec(mk(0, 4'd4, 9'h1FF, 0, 9'h000, 1, 4'd4, 16'hFEFD, 0),
                      $sformatf("stall%0d", c));
        end
        in_data[4*W +: W] = 16'h0102;
        apply_vec(mk(0, 4'd4, 9'h1FF, 1, 9'h010, 1, 4'd4, 16'h0102, 0), "stall release");
        load_pattern();

        // Asynchronous reset while FULL after an RR grant to ch5.
        apply_vec(mk(1, 4'd0, 9'h020, 1, 9'h020, 1, 4'd5, 16'h1415, 0), "rr ch5");
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_data", 32'(out_data), 32'd0);
        check("async rst out_src", 32'(out_src), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst held out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        apply_vec(mk(1, 4'd0, 9'h1FF, 1, 9'h001, 1, 4'd0, 16'h0F10, 0), "post rst rr");

        // Randomized phase against the reference model.
        do_reset();
        m_full = 0; m_src = 0; m_ptr = N - 1; m_data = '0; m_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            mode      = ($urandom_range(0, 3) != 0);
            sel       = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15))
                                                     : 4'($urandom_range(0, 8));
            in_valid  = 9'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) in_data[k*W +: W] = 16'($urandom);
            #1;
            check($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(model_ready()));
            model_clock();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(m_full));
            if (m_full != 0) begin
                check($sformatf("rnd%0d out_src", cyc), 32'(out_src), 32'(m_src));
                check($sformatf("rnd%0d out_data", cyc), 32'(out_data), 32'(m_data));
            end
            check($sformatf("rnd%0d err_sel", cyc), 32'(err_sel), 32'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mux_rr_arb

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 9, number of input channels (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 16, data width per channel.
REQ-003 The block SHALL have derived localparam SEL_W = $clog2(NUM_IN), default 4, width of select and source fields.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port mode, input, 1, arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 The block SHALL have port sel, input, SEL_W, channel index used in mode 0.
REQ-008 The block SHALL have port in_data, input, NUM_IN*WIDTH, flattened inputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_valid, input, NUM_IN, per-channel valid.
REQ-010 The block SHALL have port in_ready, output, NUM_IN, per-channel accept, one-hot or zero.
REQ-011 The block SHALL have port out_data, output, WIDTH, registered selected word.
REQ-012 The block SHALL have port out_src, output, SEL_W, index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_valid, input-side partner out_ready; out_valid output 1, out_ready input 1.
REQ-014 The block SHALL have port err_sel, output, 1, sticky flag: out-of-range sel seen in mode 0.

Function
REQ-015 The output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load SHALL be (state==EMPTY) or (out_ready and state==FULL).
REQ-017 In mode 0, grant SHALL be sel when sel<NUM_IN and in_valid[sel]=1; otherwise no grant.
REQ-018 In mode 1, grant SHALL be the first k with in_valid[k]=1, searching from ptr+1 upward with wrap at NUM_IN-1 to 0.
REQ-019 in_ready[k] SHALL be 1 only when load=1 and grant==k; a transfer on channel k is in_valid[k] and in_ready[k].
REQ-020 On a transfer, the FSM SHALL capture in_data[k] into out_data and k into out_src the next cycle and enter FULL; latency 1 cycle.
REQ-021 In FULL with out_ready=1 and no grant, the FSM SHALL go to EMPTY; out_data and out_src SHALL hold their last value.
REQ-022 In FULL with out_ready=1 and a grant, the FSM SHALL stay FULL and reload, sustaining 1 word/cycle.
REQ-023 In FULL with out_ready=0, out_data, out_src and out_valid SHALL stay stable and all in_ready SHALL be 0.
REQ-024 ptr SHALL update to k only on a mode 1 transfer; mode 0 transfers SHALL leave ptr unchanged.
REQ-025 A change of mode or sel SHALL take effect in the same cycle's grant; ptr SHALL be preserved across mode changes.
REQ-026 In mode 0 with sel>=NUM_IN, no transfer SHALL occur and err_sel SHALL set the next cycle and stay set until reset.
REQ-027 in_ready SHALL be combinational from in_valid, mode, sel, state, out_ready and ptr; out_* SHALL be register outputs only.

Reset
REQ-028 While rst=1, the block SHALL set state=EMPTY, out_valid=0, out_data=0, out_src=0, err_sel=0 and ptr=NUM_IN-1, so the first round-robin grant starts at channel 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; in_ready SHALL be 0 while rst=1.

Structure
REQ-030 Package mux_rr_arb_pkg SHALL hold the mode enum (MODE_FIXED=0, MODE_RR=1) and the FSM state enum (ST_EMPTY, ST_FULL).
REQ-031 Round-robin search SHALL live in sub-module rr_arbiter (inputs req, ptr; outputs grant_vld, grant_idx), purely combinational.

Verification
REQ-032 Mode 0, NUM_IN=9, WIDTH=16, ch3=16'h1213 valid, sel=3, out_ready=1 -> next cycle out_valid=1, out_data=16'h1213, out_src=3.
REQ-033 Mode 1, all 9 channels valid, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,...,8,0.
REQ-034 Mode 1, only ch2 and ch7 valid, out_ready=1 -> out_src alternates 2,7,2,7; no other channel gets in_ready.
REQ-035 FULL with out_data=16'hfefd, out_ready=0 for 5 cycles -> out_data, out_src stable, in_ready=0; release -> word consumed, next granted word follows the next cycle.
REQ-036 Mode 0, sel=4'hF, all channels valid -> in_ready=0, out_valid stays 0, err_sel=1 next cycle and held until rst.
REQ-037 rst pulsed while FULL in mode 1 after grant to ch5 -> out_valid=0, out_data=0 immediately; first grant after release is ch0.
